mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit with HI/LO register file for the MIPS pipeline.
- Sits in the execute stage and is driven by main-decoder signals: ismult, signedmult, isdiv, signeddiv, hiwrite, lowrite.
- Replaces the combinational HI/LO write path with a multi-cycle multiplier (configurable latency) and an iterative radix-2 divider.
- Stalls the pipeline until each operation completes.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; product is 2*WIDTH bits.
- MUL_LAT, 2, multiplier latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  execute-stage instruction is valid this cycle.
- ismult  in  1  MULT/MULTU.
- signedmult  in  1  signed multiply.
- isdiv  in  1  DIV/DIVU.
- signeddiv  in  1  signed divide.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hiwrite  in  1  MTHI request; applied only when ismult=0 and isdiv=0.
- lowrite  in  1  MTLO request; same qualification as hiwrite.
- wdata  in  WIDTH  MTHI/MTLO data.
- flush  in  1  cancel the in-flight operation (exception or branch flush).
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- stall_o  out  1  hold the pipeline.
- done_o  out  1  one-cycle pulse; HI/LO are written at the end of this cycle.

Behaviour:
- Reset (async, rst=1): state IDLE; hi_o=0, lo_o=0, stall_o=0, done_o=0; counter cleared. Applies mid-operation with no partial result written.
- States:
  - IDLE: start&ismult -> MUL; start&isdiv&b!=0 -> DIV; start&isdiv&b==0 -> DONE.
  - MUL: counts MUL_LAT-1 cycles -> DONE.
  - DIV: WIDTH iterations -> DONE.
  - DONE: -> IDLE.
- Decoder guarantees ismult and isdiv are never both 1. If both are 1, ismult wins.
- Acceptance: an op is accepted in cycle T (IDLE, start=1, flush=0).
  - stall_o is combinationally 1 in cycle T and stays 1 through the cycle before DONE.
  - stall_o=0 in the DONE cycle; done_o=1 only in the DONE cycle.
- Latency:
  - MUL: DONE in cycle T+MUL_LAT; HI/LO updated at the end of that cycle.
  - DIV: DONE in cycle T+WIDTH.
  - Divide by zero: DONE in cycle T+1.
- Multiply: 2*WIDTH product; signed (two's complement) when signedmult=1, else unsigned. HI=product[2W-1:W], LO=product[W-1:0]. Pipeline MUL_LAT register stages.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Signed mode: quotient negated if the signs of a and b differ; remainder takes the sign of a.
  - LO=quotient, HI=remainder.
  - Signed overflow (a=most-negative, b=-1): LO=a, HI=0.
  - Divide by zero: LO=all ones, HI=a.
- Operands are latched at acceptance; later changes on a/b are ignored.
- MTHI/MTLO:
  - In IDLE with hiwrite or lowrite set (and not mult/div), the selected register takes wdata at the clock edge; 0 cycles of stall.
  - hiwrite and lowrite together write both registers.
  - MT requests while state!=IDLE are ignored; the pipeline is stalled, so none arrive.
- Flush:
  - Any state -> IDLE at the next edge; HI/LO unchanged; done_o stays 0.
  - stall_o is forced 0 in any cycle where flush=1.
  - flush together with start in IDLE: start is not accepted.
- Back-to-back: start in the DONE cycle is not accepted, because stall_o=0 lets the instruction leave E. The next instruction can start in the following cycle and sees the updated HI/LO.
- hi_o and lo_o are direct register outputs; there is no internal forwarding.

Decomposition:
- defines.vh: funct codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO; MDU state encoding (IDLE, MUL, DIV, DONE, 2 bits); divide-by-zero result constants.
- Sub-module div_radix2 (parametrised WIDTH): start/busy/done handshake, signed-fixup logic, quotient/remainder outputs.
- The multiplier pipeline stays inline.

Test Plan:
- Reset mid-divide:
  - Stimulus: start DIV a=100, b=7; assert rst at iteration 10.
  - Required: hi_o=lo_o=0, stall_o=0 immediately; no done_o.
- MULT signed, WIDTH=32, MUL_LAT=2:
  - Stimulus: a=0xFFFFFFFE (-2), b=3.
  - Required: stall_o high 2 cycles; done_o at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU:
  - Stimulus: a=b=0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001 after MUL_LAT cycles.
- DIV signed:
  - Stimulus: a=-7 (0xFFFFFFF9), b=2.
  - Required: stall_o high 32 cycles; done_o at T+32; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU by zero and overflow:
  - DIVU a=5, b=0 -> done_o at T+1; LO=0xFFFFFFFF, HI=5.
  - DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- Flush and MTHI/MTLO:
  - HI=0x11, LO=0x22 preset via MTHI/MTLO (single cycle each, no stall).
  - Start DIV, flush at cycle 5 -> IDLE next edge, HI/LO remain 0x11/0x22, stall_o=0 in the flush cycle.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM state
// encoding and the record of which result source the DONE cycle commits.
package mdu_hilo_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  // Divide by zero never runs the divider: LO becomes all ones, HI the dividend.
  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_DIVZ = 2'd2
  } mdu_op_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage <-> MDU signal bundle; the pipeline drives it as master.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ismult;
  logic             signedmult;
  logic             isdiv;
  logic             signeddiv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hiwrite;
  logic             lowrite;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             stall_o;
  logic             done_o;

  modport master (
    output start, ismult, signedmult, isdiv, signeddiv, a, b,
           hiwrite, lowrite, wdata, flush,
    input  hi_o, lo_o, stall_o, done_o
  );

  modport slave (
    input  start, ismult, signedmult, isdiv, signeddiv, a, b,
           hiwrite, lowrite, wdata, flush,
    output hi_o, lo_o, stall_o, done_o
  );
endinterface

// File: rtl/mdu_hilo_div_radix2.sv
// Restoring radix-2 divider on operand magnitudes with sign fix-up on output.
// The first quotient bit is produced at the start edge; done marks the last step.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_reg, quo_reg, dvs_reg;
  logic [IW-1:0]      iter_reg;
  logic               running_reg, neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] first_step, next_step;

  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    trial = {acc, quo[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - dvs;
    if (trial >= {1'b0, dvs})
      div_step = {diff, quo[WIDTH-2:0], 1'b1};
    else
      div_step = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  assign mag_a      = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b      = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign first_step = div_step('0, mag_a, mag_b);
  assign next_step  = div_step(acc_reg, quo_reg, dvs_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      iter_reg    <= '0;
      running_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else if (start) begin
      {acc_reg, quo_reg} <= first_step;
      dvs_reg     <= mag_b;
      neg_q_reg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_reg   <= signed_op & a[WIDTH-1];
      iter_reg    <= IW'(1);
      running_reg <= 1'b1;
    end else if (abort) begin
      running_reg <= 1'b0;
    end else if (running_reg) begin
      {acc_reg, quo_reg} <= next_step;
      iter_reg    <= iter_reg + 1'b1;
      if (done)
        running_reg <= 1'b0;
    end
  end

  // Most-negative / -1 needs no special case: the magnitude quotient is
  // 2^(WIDTH-1), which already equals the dividend bit pattern.
  assign busy      = running_reg;
  assign done      = running_reg && (iter_reg == IW'(WIDTH-1));
  assign quotient  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign remainder = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage;
// holds the pipeline until each MULT/DIV result is committed in DONE.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_t         state_reg, state_next;
  mdu_op_t            op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg, opa_reg, opb_reg;
  logic               smul_reg;
  logic               accept_mul, accept_div, div_zero, mt_ok;
  logic               stall, done;
  logic               div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_comb, mul_res;

  assign div_zero   = (bus.b == '0);
  assign accept_mul = (state_reg == ST_IDLE) && bus.start && !bus.flush && bus.ismult;
  assign accept_div = (state_reg == ST_IDLE) && bus.start && !bus.flush && !bus.ismult && bus.isdiv;
  assign mt_ok      = (state_reg == ST_IDLE) && !bus.ismult && !bus.isdiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept_mul)
          state_next = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
        else if (accept_div)
          state_next = div_zero ? ST_DONE : ST_DIV;
      end
      ST_MUL:  if (cnt_reg == '0) state_next = ST_DONE;
      ST_DIV:  if (div_done || !div_busy) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
    if (bus.flush)
      state_next = ST_IDLE;
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    if (!bus.flush) begin
      stall = accept_mul || accept_div || (state_reg == ST_MUL) || (state_reg == ST_DIV);
      done  = (state_reg == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      opa_reg  <= '0;
      opb_reg  <= '0;
      smul_reg <= 1'b0;
      cnt_reg  <= '0;
      op_reg   <= OP_MUL;
    end else begin
      if (accept_mul || accept_div) begin
        opa_reg  <= bus.a;
        opb_reg  <= bus.b;
        smul_reg <= bus.signedmult;
        cnt_reg  <= CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
        op_reg   <= accept_mul ? OP_MUL : (div_zero ? OP_DIVZ : OP_DIV);
      end else if (state_reg == ST_MUL && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end

      if (done) begin
        case (op_reg)
          OP_MUL:  {hi_reg, lo_reg} <= mul_res;
          OP_DIV:  begin hi_reg <= div_rem; lo_reg <= div_quo; end
          default: begin hi_reg <= opa_reg; lo_reg <= '1;      end
        endcase
      end else if (mt_ok) begin
        if (bus.hiwrite) hi_reg <= bus.wdata;
        if (bus.lowrite) lo_reg <= bus.wdata;
      end
    end
  end

  // Operand latch is the first multiplier stage; MUL_LAT-1 product stages follow.
  assign ext_a     = smul_reg ? {{WIDTH{opa_reg[WIDTH-1]}}, opa_reg} : {{WIDTH{1'b0}}, opa_reg};
  assign ext_b     = smul_reg ? {{WIDTH{opb_reg[WIDTH-1]}}, opb_reg} : {{WIDTH{1'b0}}, opb_reg};
  assign prod_comb = ext_a * ext_b;

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_res = prod_comb;
    end else begin : g_mul_pipe
      genvar gi;
      logic [2*WIDTH-1:0] stage [MUL_LAT-1];
      always_ff @(posedge clk) stage[0] <= prod_comb;
      for (gi = 1; gi < MUL_LAT - 1; gi++) begin : g_stage
        always_ff @(posedge clk) stage[gi] <= stage[gi-1];
      end
      assign mul_res = stage[MUL_LAT-2];
    end
  endgenerate

  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div && !div_zero),
    .abort     (bus.flush),
    .signed_op (bus.signeddiv),
    .a         (bus.a),
    .b         (bus.b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign bus.hi_o    = hi_reg;
  assign bus.lo_o    = lo_reg;
  assign bus.stall_o = stall;
  assign bus.done_o  = done;
endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus random ops checked
// against an arithmetic reference model of HI/LO results and latencies.
module tb_mdu_hilo;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(WIDTH)) bus ();

  mdu_hilo #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: plain 64-bit arithmetic plus the explicit special cases.
  task automatic ref_op(input bit m, input bit sg, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] ehi, output logic [31:0] elo, output int elat);
    longint sx, sy, p, q, r;
    sx = sg ? longint'($signed(x)) : longint'({32'b0, x});
    sy = sg ? longint'($signed(y)) : longint'({32'b0, y});
    if (m) begin
      p = sx * sy;
      ehi = p[63:32]; elo = p[31:0]; elat = MUL_LAT;
    end else if (y == 32'h0) begin
      ehi = x; elo = 32'hFFFF_FFFF; elat = 1;
    end else if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      ehi = 32'h0; elo = x; elat = WIDTH;
    end else begin
      q = sx / sy; r = sx % sy;
      ehi = r[31:0]; elo = q[31:0]; elat = WIDTH;
    end
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.ismult = 0; bus.signedmult = 0; bus.isdiv = 0; bus.signeddiv = 0;
    bus.hiwrite = 0; bus.lowrite = 0; bus.flush = 0;
  endtask

  // Issues one MULT/DIV and observes it; returns done cycle offset (-1 if none),
  // number of stalled cycles before done, and stall_o during the done cycle.
  task automatic run_op(input bit m, input bit d, input bit sg, input logic [31:0] x,
                        input logic [31:0] y, output int done_cyc, output int stall_cnt,
                        output logic done_stall);
    @(negedge clk);
    bus.start = 1; bus.ismult = m; bus.isdiv = d; bus.signedmult = sg; bus.signeddiv = sg;
    bus.a = x; bus.b = y;
    #1;
    stall_cnt = bus.stall_o ? 1 : 0;
    done_cyc = -1;
    done_stall = 1'bx;
    for (int c = 1; c <= WIDTH + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        idle_inputs();
        bus.a = $urandom; bus.b = $urandom;
      end
      #1;
      if (bus.done_o) begin
        done_cyc = c; done_stall = bus.stall_o;
        break;
      end
      if (bus.stall_o) stall_cnt++;
    end
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (bus.hi_o !== 32'h0) $display("FAIL reset_hi got=%h exp=%h", bus.hi_o, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.lo_o !== 32'h0) $display("FAIL reset_lo got=%h exp=%h", bus.lo_o, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0)
      $display("FAIL reset_ctl got stall=%b done=%b exp 0/0", bus.stall_o, bus.done_o); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic check_op(input string name, input bit m, input bit d, input bit sg,
                          input logic [31:0] x, input logic [31:0] y);
    int dc, sc, elat; logic ds; logic [31:0] ehi, elo;
    ref_op(m, sg, x, y, ehi, elo, elat);
    run_op(m, d, sg, x, y, dc, sc, ds);
    total_cnt++; if (dc !== elat) $display("FAIL %s_latency got=%0d exp=%0d", name, dc, elat); else pass_cnt++;
    total_cnt++; if (sc !== elat || ds !== 1'b0)
      $display("FAIL %s_stall got cycles=%0d done_stall=%b exp cycles=%0d done_stall=0", name, sc, ds, elat); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.hi_o !== ehi || bus.lo_o !== elo)
      $display("FAIL %s_result got hi=%h lo=%h exp hi=%h lo=%h", name, bus.hi_o, bus.lo_o, ehi, elo); else pass_cnt++;
    $display("op %s a=%h b=%h hi=%h lo=%h lat=%0d", name, x, y, bus.hi_o, bus.lo_o, dc);
  endtask

  task automatic test_mult_signed();
    check_op("mult_signed", 1, 0, 1, 32'hFFFF_FFFE, 32'h3);
    total_cnt++; if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFA)
      $display("FAIL mult_signed_const got hi=%h lo=%h exp hi=ffffffff lo=fffffffa", bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_multu();
    check_op("multu", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total_cnt++; if (bus.hi_o !== 32'hFFFF_FFFE || bus.lo_o !== 32'h0000_0001)
      $display("FAIL multu_const got hi=%h lo=%h exp hi=fffffffe lo=00000001", bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_div_signed();
    check_op("div_signed", 0, 1, 1, 32'hFFFF_FFF9, 32'h2);
    total_cnt++; if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFD)
      $display("FAIL div_signed_const got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_div_special();
    check_op("divu_zero", 0, 1, 0, 32'h5, 32'h0);
    total_cnt++; if (bus.hi_o !== 32'h5 || bus.lo_o !== 32'hFFFF_FFFF)
      $display("FAIL divu_zero_const got hi=%h lo=%h exp hi=00000005 lo=ffffffff", bus.hi_o, bus.lo_o); else pass_cnt++;
    check_op("div_ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    total_cnt++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h8000_0000)
      $display("FAIL div_ovf_const got hi=%h lo=%h exp hi=00000000 lo=80000000", bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_mt_flush();
    bit seen_done;
    @(negedge clk);
    bus.start = 1; bus.hiwrite = 1; bus.wdata = 32'h11; #1;
    total_cnt++; if (bus.stall_o !== 1'b0) $display("FAIL mthi_stall got=%b exp=0", bus.stall_o); else pass_cnt++;
    @(negedge clk);
    bus.hiwrite = 0; bus.lowrite = 1; bus.wdata = 32'h22; #1;
    total_cnt++; if (bus.hi_o !== 32'h11 || bus.stall_o !== 1'b0)
      $display("FAIL mthi_write got hi=%h stall=%b exp hi=00000011 stall=0", bus.hi_o, bus.stall_o); else pass_cnt++;
    @(negedge clk);
    idle_inputs(); #1;
    total_cnt++; if (bus.lo_o !== 32'h22) $display("FAIL mtlo_write got=%h exp=00000022", bus.lo_o); else pass_cnt++;
    @(negedge clk);
    bus.start = 1; bus.isdiv = 1; bus.signeddiv = 0; bus.a = 32'd100; bus.b = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) idle_inputs();
    end
    bus.flush = 1; #1;
    total_cnt++; if (bus.stall_o !== 1'b0) $display("FAIL flush_stall got=%b exp=0", bus.stall_o); else pass_cnt++;
    @(negedge clk);
    bus.flush = 0; #1;
    total_cnt++; if (bus.stall_o !== 1'b0) $display("FAIL flush_idle got stall=%b exp=0", bus.stall_o); else pass_cnt++;
    seen_done = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(negedge clk); #1;
      if (bus.done_o) seen_done = 1;
    end
    total_cnt++; if (seen_done !== 1'b0) $display("FAIL flush_no_done got done=%b exp=0", seen_done); else pass_cnt++;
    total_cnt++; if (bus.hi_o !== 32'h11 || bus.lo_o !== 32'h22)
      $display("FAIL flush_hilo got hi=%h lo=%h exp hi=00000011 lo=00000022", bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_div();
    bit seen_done;
    @(negedge clk);
    bus.start = 1; bus.isdiv = 1; bus.signeddiv = 1; bus.a = 32'd100; bus.b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) idle_inputs();
    end
    rst = 1; #1;
    total_cnt++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.stall_o !== 1'b0)
      $display("FAIL rst_mid_div got hi=%h lo=%h stall=%b exp 0/0/0", bus.hi_o, bus.lo_o, bus.stall_o); else pass_cnt++;
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (bus.done_o) seen_done = 1;
    end
    rst = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(negedge clk); #1;
      if (bus.done_o || bus.stall_o) seen_done = 1;
    end
    total_cnt++; if (seen_done !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0)
      $display("FAIL rst_mid_div_after got activity=%b hi=%h lo=%h exp 0/0/0", seen_done, bus.hi_o, bus.lo_o); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] x, y, ehi, elo, wd;
    int kind, hw, lw;
    ehi = bus.hi_o; elo = bus.lo_o;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'h0;
      if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (kind == 4) begin
        hw = $urandom_range(0, 2); lw = (hw == 0) ? 1 : $urandom_range(0, 1);
        wd = $urandom;
        @(negedge clk);
        bus.start = 1; bus.hiwrite = hw[0] | hw[1]; bus.lowrite = lw[0]; bus.wdata = wd; #1;
        total_cnt++; if (bus.stall_o !== 1'b0) $display("FAIL rand_mt_stall got=%b exp=0", bus.stall_o); else pass_cnt++;
        if (hw != 0) ehi = wd;
        if (lw != 0) elo = wd;
        @(negedge clk);
        idle_inputs(); #1;
        total_cnt++; if (bus.hi_o !== ehi || bus.lo_o !== elo)
          $display("FAIL rand_mt got hi=%h lo=%h exp hi=%h lo=%h", bus.hi_o, bus.lo_o, ehi, elo); else pass_cnt++;
        $display("op mt hw=%0d lw=%0d wdata=%h hi=%h lo=%h", hw, lw, wd, bus.hi_o, bus.lo_o);
      end else begin
        check_op("rand", kind < 2, kind >= 2, kind[0], x, y);
        ehi = bus.hi_o; elo = bus.lo_o;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, sc; logic ds;
    run_op(1, 0, 0, 32'd6, 32'd7, dc, sc, ds);
    bus.start = 1; bus.isdiv = 1; bus.a = 32'd9; bus.b = 32'd2;
    @(negedge clk);
    idle_inputs(); #1;
    total_cnt++; if (bus.stall_o !== 1'b0 || bus.lo_o !== 32'd42 || bus.hi_o !== 32'd0)
      $display("FAIL b2b_not_accepted got stall=%b hi=%h lo=%h exp 0/00000000/0000002a", bus.stall_o, bus.hi_o, bus.lo_o); else pass_cnt++;
    check_op("b2b_div", 0, 1, 0, 32'd9, 32'd2);
    run_op(0, 1, 0, 32'd50, 32'd0, dc, sc, ds);
    check_op("b2b_mult", 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  initial begin
    bus.a = '0; bus.b = '0; bus.wdata = '0;
    idle_inputs();
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_div_special();
    test_mt_flush();
    test_reset_mid_div();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
